pipeline_trace_buffer: RTL and testbench

On-chip logic-analyser block for the pipelined MIPS core. It samples up to CHANNELS probe words per qualified cycle into a circular buffer and stops a programmable number of samples after a trigger. It then streams the captured window, oldest first, over a valid/ready port. It replaces per-cycle file dumps of stage signals with a synthesizable capture that also runs on hardware.

---
 rtl/pipeline_trace_buffer_pkg.sv | 16 +
 rtl/pipeline_trace_buffer_trace_mem.sv | 29 ++
 rtl/pipeline_trace_buffer.sv | 177 +++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM state encodings and timestamp width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pipeline_trace_buffer_pkg;

    // Encodings are visible on the state output port, so they are fixed values.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_POST    = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    localparam int TS_W = 16;

endpackage

// File: rtl/pipeline_trace_buffer_trace_mem.sv
// Capture storage: DEPTH x WIDTH flop array, one synchronous write port, one asynchronous read port.
// Latency: write lands on the clk edge; read data follows rd_addr combinationally.
// Backpressure: none; the caller decides when to write and which entry to read.
// Ports: clk, wr_en/wr_addr/wr_data (write side), rd_addr/rd_data (read side).
// Contents are deliberately not reset so a capture survives a reset for inspection.
module trace_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Logic-analyser capture: circular sample buffer, stops POST_TRIG samples after a trigger, then streams oldest-first.
// Latency: one edge per sample write/state change; readout one word per cycle when rd_ready stays high.
// Backpressure: rd_ready=0 holds rd_data/rd_last/rd_ts stable; capture itself never stalls the pipeline.
// Ports: clk, resetManual (async active-low), arm, sample_en, trigger, probe (capture side);
//        rd_valid/rd_ready/rd_data/rd_last[/rd_ts] (readout side); state, fill_count (status).
// Optional feature macro TRACE_TIMESTAMP_EN: adds a 16-bit cycle counter stored with each sample and the rd_ts port.
module pipeline_trace_buffer
    import pipeline_trace_buffer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                         clk,
    input  logic                         resetManual,
    input  logic                         arm,
    input  logic                         sample_en,
    input  logic                         trigger,
    input  logic [CHANNELS*DATA_W-1:0]   probe,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [CHANNELS*DATA_W-1:0]   rd_data,
    output logic                         rd_last,
`ifdef TRACE_TIMESTAMP_EN
    output logic [15:0]                  rd_ts,
`endif
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH):0]       fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = CHANNELS * DATA_W;
`ifdef TRACE_TIMESTAMP_EN
    localparam int MW = PW + TS_W;
`else
    localparam int MW = PW;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] fill_count_q, fill_count_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          wr_en;
    logic          go_readout;
    logic [MW-1:0] mem_wr_data;
    logic [MW-1:0] mem_rd_data;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        post_cnt_d   = post_cnt_q;
        fill_count_d = fill_count_q;
        remaining_d  = remaining_q;
        wr_en        = 1'b0;
        go_readout   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d      = ST_ARMED;
                    wr_ptr_d     = '0;
                    fill_count_d = '0;
                end
            end
            ST_ARMED: begin
                if (sample_en) begin
                    wr_en = 1'b1;
                    if (trigger) begin
                        if (POST_TRIG == 0) begin
                            go_readout = 1'b1;
                        end else begin
                            post_cnt_d = AW'(POST_TRIG);
                            state_d    = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (sample_en) begin
                    wr_en      = 1'b1;
                    post_cnt_d = post_cnt_q - AW'(1);
                    if (post_cnt_q == AW'(1)) begin
                        go_readout = 1'b1;
                    end
                end
            end
            ST_READOUT: begin
                if (rd_ready) begin
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared bookkeeping for any sample write; the pointer wraps naturally at DEPTH.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_count_q != CW'(DEPTH)) begin
                fill_count_d = fill_count_q + CW'(1);
            end
        end

        // Oldest entry sits fill_count behind the post-write pointer. When the
        // buffer is full the low bits of fill_count are zero, so rd_ptr lands on
        // wr_ptr, i.e. the entry about to be overwritten next.
        if (go_readout) begin
            state_d     = ST_READOUT;
            rd_ptr_d    = wr_ptr_d - fill_count_d[AW-1:0];
            remaining_d = fill_count_d;
        end
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            post_cnt_q   <= '0;
            fill_count_q <= '0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            post_cnt_q   <= post_cnt_d;
            fill_count_q <= fill_count_d;
            remaining_q  <= remaining_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign mem_wr_data = {ts_q, probe};
    assign rd_ts       = mem_rd_data[PW +: TS_W];
`else
    assign mem_wr_data = probe;
`endif

    trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (mem_wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign rd_data    = mem_rd_data[PW-1:0];
    assign rd_valid   = (state_q == ST_READOUT);
    assign rd_last    = (state_q == ST_READOUT) && (remaining_q == CW'(1));
    assign state      = state_q;
    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
module tb_pipeline_trace_buffer;

    localparam int DATA_W    = 8;
    localparam int CHANNELS  = 2;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 3;

    logic        clk = 1'b0;
    logic        resetManual = 1'b0;
    logic        arm = 1'b0;
    logic        sample_en = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] probe = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [15:0] rd_data;
    logic        rd_last;
    logic [1:0]  state;
    logic [3:0]  fill_count;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_trace_buffer #(
        .DATA_W    (DATA_W),
        .CHANNELS  (CHANNELS),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk         (clk),
        .resetManual (resetManual),
        .arm         (arm),
        .sample_en   (sample_en),
        .trigger     (trigger),
        .probe       (probe),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts       (rd_ts),
`endif
        .state       (state),
        .fill_count  (fill_count)
    );

    // Probe pattern: ch0 = k, ch1 = ~k.
    function automatic logic [15:0] pw(input logic [7:0] k);
        return {~k, k};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [7:0] k, input logic trig);
        sample_en = 1'b1;
        trigger   = trig;
        probe     = pw(k);
        step();
        sample_en = 1'b0;
        trigger   = 1'b0;
    endtask

    task automatic test_reset();
        resetManual = 1'b0;
        step();
        step();
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || fill_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_init: state=%0d rd_valid=%b rd_last=%b fill=%0d, want 0/0/0/0",
                     state, rd_valid, rd_last, fill_count);
        end
        resetManual = 1'b1;
        step();
        do_arm();
        feed(8'h50, 1'b0);
        feed(8'h51, 1'b0);
        feed(8'h52, 1'b0);
        checks++;
        if (state !== 2'd1 || fill_count !== 4'd3) begin
            errors++;
            $display("FAIL reset_prefill: state=%0d fill=%0d, want 1/3", state, fill_count);
        end
        // Asynchronous assertion mid-cycle, checked before the next edge.
        #3 resetManual = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || fill_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: state=%0d rd_valid=%b rd_last=%b fill=%0d, want 0/0/0/0",
                     state, rd_valid, rd_last, fill_count);
        end
        step();
        resetManual = 1'b1;
        step();
        do_arm();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL reset_rearm: state=%0d, want 1", state);
        end
        // Return to IDLE for the following scenarios.
        resetManual = 1'b0;
        step();
        resetManual = 1'b1;
        step();
    endtask

    task automatic test_wrap_capture();
        do_arm();
        for (int k = 0; k < 12; k++) begin
            if (k >= 10) rd_ready = 1'b0;
            feed(8'(k), k == 6);
            if (k == 8) begin
                checks++;
                if (state !== 2'd2) begin
                    errors++;
                    $display("FAIL wrap_post: state=%0d, want 2", state);
                end
            end
            if (k == 9) begin
                checks++;
                if (state !== 2'd3 || fill_count !== 4'd8 || rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_enter_readout: state=%0d fill=%0d rd_valid=%b, want 3/8/1",
                             state, fill_count, rd_valid);
                end
            end
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== pw(8'(2 + i)) || rd_last !== (i == 7)) begin
                errors++;
                $display("FAIL wrap_word%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                         i, rd_valid, rd_data, rd_last, pw(8'(2 + i)), (i == 7));
            end
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: state=%0d rd_valid=%b, want 0/0", state, rd_valid);
        end
    endtask

    task automatic test_first_trigger();
        do_arm();
        feed(8'd0, 1'b1);
        feed(8'd1, 1'b0);
        feed(8'd2, 1'b0);
        feed(8'd3, 1'b0);
        checks++;
        if (state !== 2'd3 || fill_count !== 4'd4) begin
            errors++;
            $display("FAIL first_trig_fill: state=%0d fill=%0d, want 3/4", state, fill_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== pw(8'(i)) || rd_last !== (i == 3)) begin
                errors++;
                $display("FAIL first_trig_word%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                         i, rd_valid, rd_data, rd_last, pw(8'(i)), (i == 3));
            end
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL first_trig_done: state=%0d, want 0", state);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        do_arm();
        feed(8'h20, 1'b1);
        feed(8'h21, 1'b0);
        feed(8'h22, 1'b0);
        feed(8'h23, 1'b0);
        for (int cyc = 0; cyc < 40 && state == 2'd3; cyc++) begin
            rd_ready = pat[cyc % 4];
            checks++;
            if (rd_data !== pw(8'(8'h20 + idx)) || rd_last !== (idx == 3)) begin
                errors++;
                $display("FAIL bp_cycle%0d: data=%h last=%b, want %h/%b",
                         cyc, rd_data, rd_last, pw(8'(8'h20 + idx)), (idx == 3));
            end
            if (rd_ready) idx++;
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (idx !== 4 || state !== 2'd0) begin
            errors++;
            $display("FAIL bp_count: words=%0d state=%0d, want 4/0", idx, state);
        end
    endtask

    task automatic test_sample_gaps();
        int cyc;
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] prev_ts;
`endif
        cyc = 0;
        do_arm();
        // Even cycles sample; a trigger on odd cycle 1 (sample_en=0) must be ignored.
        while (state != 2'd3 && cyc < 20) begin
            sample_en = (cyc % 2 == 0);
            trigger   = (cyc == 1) || (cyc == 4);
            probe     = pw(8'(8'h40 + cyc));
            step();
            cyc++;
        end
        sample_en = 1'b0;
        trigger   = 1'b0;
        checks++;
        if (state !== 2'd3 || fill_count !== 4'd6) begin
            errors++;
            $display("FAIL gaps_fill: state=%0d fill=%0d, want 3/6", state, fill_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rd_data !== pw(8'(8'h40 + 2 * i)) || rd_last !== (i == 5)) begin
                errors++;
                $display("FAIL gaps_word%0d: data=%h last=%b, want %h/%b",
                         i, rd_data, rd_last, pw(8'(8'h40 + 2 * i)), (i == 5));
            end
`ifdef TRACE_TIMESTAMP_EN
            if (i > 0) begin
                checks++;
                if (rd_ts - prev_ts !== 16'd2) begin
                    errors++;
                    $display("FAIL gaps_ts%0d: delta=%0d, want 2", i, rd_ts - prev_ts);
                end
            end
            prev_ts = rd_ts;
`endif
            step();
        end
        rd_ready = 1'b0;
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL gaps_done: state=%0d, want 0", state);
        end
    endtask

    task automatic test_ignored_arm();
        do_arm();
        feed(8'h30, 1'b1);
        arm = 1'b1;
        feed(8'h31, 1'b0);
        arm = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL ign_arm_post: state=%0d, want 2", state);
        end
        feed(8'h32, 1'b0);
        feed(8'h33, 1'b0);
        arm = 1'b1;
        rd_ready = 1'b0;
        step();
        arm = 1'b0;
        checks++;
        if (state !== 2'd3 || rd_data !== pw(8'h30)) begin
            errors++;
            $display("FAIL ign_arm_readout: state=%0d data=%h, want 3/%h", state, rd_data, pw(8'h30));
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) arm = 1'b1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== pw(8'(8'h30 + i)) || rd_last !== (i == 3)) begin
                errors++;
                $display("FAIL ign_arm_word%0d: valid=%b data=%h last=%b, want 1/%h/%b",
                         i, rd_valid, rd_data, rd_last, pw(8'(8'h30 + i)), (i == 3));
            end
            step();
            arm = 1'b0;
        end
        rd_ready = 1'b0;
        checks++;
        if (state !== 2'd0 || fill_count !== 4'd4) begin
            errors++;
            $display("FAIL ign_arm_done: state=%0d fill=%0d, want 0/4", state, fill_count);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_capture();
        test_first_trigger();
        test_backpressure();
        test_sample_gaps();
        test_ignored_arm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
